// File: rtl/sr_pkg.sv
// Shared types and constants for the set/reset pulse encoder.
package sr_pkg;

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        SET_PULSE = 3'd1,
        CLR_PULSE = 3'd2,
        GAP       = 3'd3,
        IDLE      = 3'd4
    } sr_state_t;

    localparam int GAP_CYCLES = 1;

endpackage

// File: rtl/sr_stable_cnt.sv
// Debounce counter: counts consecutive cycles of mismatch between d and the tracked latch value.
module sr_stable_cnt #(
    parameter int STABLE_N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic mismatch,
    output logic stable
);

    localparam int CW = $clog2(STABLE_N + 1);

    logic [CW-1:0] r_count;

    // Saturates at STABLE_N so a long mismatch can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (reset || clear || !mismatch) begin
            r_count <= '0;
        end else if (r_count != CW'(STABLE_N)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flags the edge on which the count reaches STABLE_N, so the registered pulse
    // appears in the very cycle the debounce window completes.
    assign stable = mismatch && (r_count == CW'(STABLE_N - 1));

endmodule

// File: rtl/sr_pulse_encoder.sv
// Level-to-pulse encoder driving a NOR RS latch with non-overlapping set/clr pulses.
// Define SR_EVENT_COUNT_EN to add the saturating set_cnt/clr_cnt event counters.
module sr_pulse_encoder
    import sr_pkg::*;
#(
    parameter int PULSE_W  = 2,
    parameter int STABLE_N = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    output logic             set_p,
    output logic             clr_p,
    output logic             q_track,
`ifdef SR_EVENT_COUNT_EN
    output logic             busy,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] clr_cnt
`else
    output logic             busy
`endif
);

    localparam int PCW = $clog2(PULSE_W + 1);

    sr_state_t      r_state;
    sr_state_t      w_nextState;
    logic [PCW-1:0] r_pcnt;
    logic           r_qTrack;
    logic           r_setP;
    logic           r_clrP;
    logic           r_initPulse;
    logic           w_stable;
    logic           w_pulseLast;
    logic           w_gapLast;

    assign w_pulseLast = (r_pcnt == PCW'(PULSE_W - 1));
    assign w_gapLast   = (r_pcnt == PCW'(GAP_CYCLES - 1));

    sr_stable_cnt #(
        .STABLE_N (STABLE_N)
    ) u_stableCnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (r_state != IDLE),
        .mismatch (d != r_qTrack),
        .stable   (w_stable)
    );

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            INIT:      w_nextState = CLR_PULSE;
            SET_PULSE: if (w_pulseLast) w_nextState = GAP;
            CLR_PULSE: if (w_pulseLast) w_nextState = GAP;
            GAP:       if (w_gapLast)   w_nextState = IDLE;
            IDLE:      if (w_stable)    w_nextState = d ? SET_PULSE : CLR_PULSE;
            default:   w_nextState = INIT;
        endcase
    end

    // Pulse outputs are registered from the next state so they never overlap or glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= INIT;
            r_pcnt      <= '0;
            r_qTrack    <= 1'b0;
            r_setP      <= 1'b0;
            r_clrP      <= 1'b0;
            r_initPulse <= 1'b1;
        end else begin
            r_state <= w_nextState;
            r_setP  <= (w_nextState == SET_PULSE);
            r_clrP  <= (w_nextState == CLR_PULSE);
            if (w_nextState != r_state) begin
                r_pcnt <= '0;
            end else if (r_state == SET_PULSE || r_state == CLR_PULSE || r_state == GAP) begin
                r_pcnt <= r_pcnt + 1'b1;
            end
            if (r_state == SET_PULSE && w_pulseLast) begin
                r_qTrack <= 1'b1;
            end
            if (r_state == CLR_PULSE && w_pulseLast) begin
                r_qTrack    <= 1'b0;
                r_initPulse <= 1'b0;
            end
        end
    end

    assign set_p   = r_setP;
    assign clr_p   = r_clrP;
    assign q_track = r_qTrack;
    assign busy    = (r_state != IDLE);

`ifdef SR_EVENT_COUNT_EN
    logic [CNT_W-1:0] r_setCnt;
    logic [CNT_W-1:0] r_clrCnt;

    // The power-up clear pulse is not a real event, so it is kept out of clr_cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_setCnt <= '0;
            r_clrCnt <= '0;
        end else begin
            if (r_state == SET_PULSE && w_pulseLast && r_setCnt != '1) begin
                r_setCnt <= r_setCnt + 1'b1;
            end
            if (r_state == CLR_PULSE && w_pulseLast && !r_initPulse && r_clrCnt != '1) begin
                r_clrCnt <= r_clrCnt + 1'b1;
            end
        end
    end

    assign set_cnt = r_setCnt;
    assign clr_cnt = r_clrCnt;
`endif

endmodule

// File: tb/tb_sr_pulse_encoder.sv
// Directed self-checking bench for sr_pulse_encoder (PULSE_W=2, STABLE_N=4).
module tb_sr_pulse_encoder;

    logic clk;
    logic reset;
    logic d;
    logic set_p;
    logic clr_p;
    logic q_track;
    logic busy;
`ifdef SR_EVENT_COUNT_EN
    logic [7:0] set_cnt;
    logic [7:0] clr_cnt;
`endif

    int assertCount = 0;
    int failCount   = 0;

    sr_pulse_encoder #(
        .PULSE_W  (2),
        .STABLE_N (4),
        .CNT_W    (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .d       (d),
        .set_p   (set_p),
        .clr_p   (clr_p),
        .q_track (q_track),
`ifdef SR_EVENT_COUNT_EN
        .busy    (busy),
        .set_cnt (set_cnt),
        .clr_cnt (clr_cnt)
`else
        .busy    (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic expSet, input logic expClr,
                              input logic expQ, input logic expBusy);
        checkOutput({tag, ".set_p"},   32'(set_p),   32'(expSet));
        checkOutput({tag, ".clr_p"},   32'(clr_p),   32'(expClr));
        checkOutput({tag, ".q_track"}, 32'(q_track), 32'(expQ));
        checkOutput({tag, ".busy"},    32'(busy),    32'(expBusy));
    endtask

    // Advance one clock and land just after the edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rstVal, input logic dVal);
        reset = rstVal;
        d     = dVal;
    endtask

    // The set and clear pulses must never overlap, not even during reset.
    always @(negedge clk) begin
        checkOutput("exclusive", 32'(set_p & clr_p), 32'd0);
    end

    initial begin
        applyStimulus(1'b1, 1'b0);
        repeat (3) tick();
        checkState("reset", 1'b0, 1'b0, 1'b0, 1'b1);

        // Release: power-up clear pulse in cycles 0-1, gap in 2, idle from 3.
        applyStimulus(1'b0, 1'b0);
        tick(); checkState("init.c0", 1'b0, 1'b1, 1'b0, 1'b1);
        tick(); checkState("init.c1", 1'b0, 1'b1, 1'b0, 1'b1);
        tick(); checkState("init.gap", 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); checkState("init.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // A 3-cycle glitch is one short of the debounce window.
        applyStimulus(1'b0, 1'b1);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkState("glitch", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // d rises, then falls during the set pulse: set completes, then clear follows.
        applyStimulus(1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkState("bounce.wait", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick(); checkState("bounce.set0", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        tick(); checkState("bounce.set1", 1'b1, 1'b0, 1'b0, 1'b1);
        tick(); checkState("bounce.gap", 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); checkState("bounce.idle", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkState("bounce.debounce", 1'b0, 1'b0, 1'b1, 1'b0);
        end
        tick(); checkState("bounce.clr0", 1'b0, 1'b1, 1'b1, 1'b1);
        tick(); checkState("bounce.clr1", 1'b0, 1'b1, 1'b1, 1'b1);
        tick(); checkState("bounce.gap2", 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); checkState("bounce.idle2", 1'b0, 1'b0, 1'b0, 1'b0);

        // Clean rising edge: set_p in t+4..t+5, q_track from t+6, idle from t+7.
        applyStimulus(1'b0, 1'b1);
        repeat (3) tick();
        checkState("rise.t3", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); checkState("rise.t4", 1'b1, 1'b0, 1'b0, 1'b1);
        tick(); checkState("rise.t5", 1'b1, 1'b0, 1'b0, 1'b1);
        tick(); checkState("rise.t6", 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); checkState("rise.t7", 1'b0, 1'b0, 1'b1, 1'b0);

        // Clean falling edge back to 0.
        applyStimulus(1'b0, 1'b0);
        repeat (4) tick();
        checkState("fall.t4", 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) tick();
        checkState("fall.t7", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted during the first set_p cycle.
        applyStimulus(1'b0, 1'b1);
        repeat (4) tick();
        checkState("rstmid.set0", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        tick(); checkState("rstmid.drop", 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); checkState("rstmid.hold", 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        tick(); checkState("rstmid.c0", 1'b0, 1'b1, 1'b0, 1'b1);
        tick(); checkState("rstmid.c1", 1'b0, 1'b1, 1'b0, 1'b1);
        tick(); checkState("rstmid.gap", 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); checkState("rstmid.idle", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SR_EVENT_COUNT_EN
        // Counters start from the reset above; the power-up clear must not count.
        checkOutput("cnt.set0", 32'(set_cnt), 32'd0);
        checkOutput("cnt.clr0", 32'(clr_cnt), 32'd0);
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'b0, 1'b1);
            repeat (7) tick();
            applyStimulus(1'b0, 1'b0);
            repeat (7) tick();
            if (n == 0) begin
                checkOutput("cnt.set1", 32'(set_cnt), 32'd1);
                checkOutput("cnt.clr1", 32'(clr_cnt), 32'd1);
            end
        end
        checkOutput("cnt.setSat", 32'(set_cnt), 32'd255);
        checkOutput("cnt.clrSat", 32'(clr_cnt), 32'd255);
        checkState("cnt.final", 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
